// File: rtl/rv_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile_if
// Description : Write/read bus bundle between the RV523 datapath and its
//               integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [XLEN-1:0] rdata1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata2;
    logic            wr_err;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wr_err
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/rv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile
// Description : RV523 integer register file, 2 combinational read ports,
//               1 synchronous write port, x0 hardwired to zero.
//               Optional write-to-read forwarding: RV523_REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    rv_regfile_if.slave bus
);

    localparam int          c_nleaf = 2 ** AW;
    // One extra bit so NREGS == 2**AW is representable in the compare.
    localparam logic [AW:0] c_nregs = (AW + 1)'(NREGS);

    logic [XLEN-1:0]         r_regs [1:NREGS-1];
    logic                    r_wr_err;
    logic                    w_wr_oor;
    logic                    w_wr_ok;
    logic [c_nleaf*XLEN-1:0] w_leaves;
    logic [XLEN-1:0]         w_rd1;
    logic [XLEN-1:0]         w_rd2;

    assign w_wr_oor = ({1'b0, bus.waddr} >= c_nregs);
    assign w_wr_ok  = bus.we && (bus.waddr != '0) && !w_wr_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_wr_ok && (bus.waddr == AW'(i))) begin
                    r_regs[i] <= bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (bus.we) begin
            r_wr_err <= w_wr_oor;
        end
    end

    assign bus.wr_err = r_wr_err;

    // Leaves of the read tree: x0 and indices beyond NREGS read as zero.
    for (genvar i = 0; i < c_nleaf; i++) begin : g_leaf
        if ((i >= 1) && (i < NREGS)) begin : g_live
            assign w_leaves[i*XLEN +: XLEN] = r_regs[i];
        end else begin : g_zero
            assign w_leaves[i*XLEN +: XLEN] = '0;
        end
    end

    // 2:1 mux as AOI22 followed by an inverter.
    function automatic logic [XLEN-1:0] f_mux2(
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] hi,
        input logic            sel
    );
        logic [XLEN-1:0] aoi;
        aoi = ~((hi & {XLEN{sel}}) | (lo & {XLEN{~sel}}));
        return ~aoi;
    endfunction

    // Binary mux tree, one level per address bit starting from the LSB.
    function automatic logic [XLEN-1:0] f_tree(
        input logic [c_nleaf*XLEN-1:0] leaves,
        input logic [AW-1:0]           sel
    );
        logic [XLEN-1:0] v [c_nleaf];
        for (int i = 0; i < c_nleaf; i++) begin
            v[i] = leaves[i*XLEN +: XLEN];
        end
        for (int d = 0; d < AW; d++) begin
            for (int j = 0; j < (c_nleaf >> (d + 1)); j++) begin
                v[j] = f_mux2(v[2*j], v[2*j+1], sel[d]);
            end
        end
        return v[0];
    endfunction

    assign w_rd1 = f_tree(w_leaves, bus.raddr1);
    assign w_rd2 = f_tree(w_leaves, bus.raddr2);

`ifdef RV523_REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1     = w_wr_ok && (bus.raddr1 == bus.waddr);
    assign w_fwd2     = w_wr_ok && (bus.raddr2 == bus.waddr);
    assign bus.rdata1 = f_mux2(w_rd1, bus.wdata, w_fwd1);
    assign bus.rdata2 = f_mux2(w_rd2, bus.wdata, w_fwd2);
`else
    assign bus.rdata1 = w_rd1;
    assign bus.rdata2 = w_rd2;
`endif

`ifndef SYNTHESIS
    if ((XLEN < 4) || (XLEN > 32) || ((NREGS != 16) && (NREGS != 32)) ||
        ((2 ** AW) < NREGS)) begin : g_param_chk
        $error("rv_regfile: illegal XLEN/NREGS/AW combination");
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({bus.we, bus.waddr}))
                else $error("rv_regfile: X on we/waddr out of reset");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_regfile
// Description : Self-checking bench for rv_regfile: RV32I, RV32E and 8-bit
//               builds driven in lockstep against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_regfile;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_regfile_if #(.XLEN(32), .AW(5)) bus32 ();
    rv_regfile_if #(.XLEN(32), .AW(5)) busE ();
    rv_regfile_if #(.XLEN(8),  .AW(5)) bus8 ();

    rv_regfile #(.XLEN(32), .NREGS(32), .AW(5)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    rv_regfile #(.XLEN(32), .NREGS(16), .AW(5)) u_dutE  (.clk(clk), .rst_n(rst_n), .bus(busE));
    rv_regfile #(.XLEN(8),  .NREGS(32), .AW(5)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic        cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;
    logic [4:0]  cur_r1;
    logic [4:0]  cur_r2;

    // Model: index 0 = RV32I, 1 = RV32E, 2 = 8-bit build.
    logic [31:0] mem [3][32];
    bit          err [3];

    function automatic int nreg(int b);
        return (b == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] wmask(int b);
        return (b == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_rd(int b, logic [4:0] ra);
        if ((ra == 5'd0) || (int'(ra) >= nreg(b))) return 32'h0;
`ifdef RV523_REGFILE_BYPASS_EN
        if (cur_we && (ra == cur_wa)) return cur_wd & wmask(b);
`endif
        return mem[b][ra];
    endfunction

    function automatic logic [31:0] act(int b, int p);
        case (b)
            0:       return (p == 1) ? bus32.rdata1 : (p == 2) ? bus32.rdata2 : {31'b0, bus32.wr_err};
            1:       return (p == 1) ? busE.rdata1  : (p == 2) ? busE.rdata2  : {31'b0, busE.wr_err};
            default: return (p == 1) ? {24'b0, bus8.rdata1} : (p == 2) ? {24'b0, bus8.rdata2} : {31'b0, bus8.wr_err};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        cur_we = we; cur_wa = wa; cur_wd = wd; cur_r1 = r1; cur_r2 = r2;
        bus32.we = we; bus32.waddr = wa; bus32.wdata = wd;      bus32.raddr1 = r1; bus32.raddr2 = r2;
        busE.we  = we; busE.waddr  = wa; busE.wdata  = wd;      busE.raddr1  = r1; busE.raddr2  = r2;
        bus8.we  = we; bus8.waddr  = wa; bus8.wdata  = wd[7:0]; bus8.raddr1  = r1; bus8.raddr2  = r2;
    endtask

    task automatic model_edge();
        if (cur_we) begin
            for (int b = 0; b < 3; b++) begin
                if ((cur_wa != 5'd0) && (int'(cur_wa) < nreg(b))) mem[b][cur_wa] = cur_wd & wmask(b);
                err[b] = (int'(cur_wa) >= nreg(b));
            end
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 32; i++) mem[b][i] = 32'h0;
            err[b] = 1'b0;
        end
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        drive(we, wa, wd, r1, r2);
        @(posedge clk);
        model_edge();
    endtask

    // Every cycle, shortly before the rising edge, all outputs vs. the model.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                for (int b = 0; b < 3; b++) begin
                    chk($sformatf("b%0d rdata1 x%0d", b, cur_r1), act(b, 1), exp_rd(b, cur_r1));
                    chk($sformatf("b%0d rdata2 x%0d", b, cur_r2), act(b, 2), exp_rd(b, cur_r2));
                    chk($sformatf("b%0d wr_err", b), act(b, 3), {31'b0, err[b]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset rdata1 x5", bus32.rdata1, 32'h0);
        chk("reset wr_err", {31'b0, bus32.wr_err}, 32'h0);

        // Preload, out-of-range write and recovery on the RV32E build.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        #1 chk("x5 preload", bus32.rdata1, 32'hDEAD_BEEF);
        step(1'b1, 5'd20, 32'h55, 5'd20, 5'd0);
        #1 chk("E oor wr_err", {31'b0, busE.wr_err}, 32'h1);
        chk("E oor read x20", busE.rdata1, 32'h0);
        chk("I x20 write", bus32.rdata1, 32'h55);
        step(1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
        #1 chk("E wr_err clears", {31'b0, busE.wr_err}, 32'h0);
        step(1'b1, 5'd20, 32'h56, 5'd5, 5'd0);

        // Asynchronous reset mid-cycle; a write held during reset is lost.
        @(negedge clk);
        chk_en = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        #1 chk("pre-reset x5", bus32.rdata1, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1 chk("async reset x5", bus32.rdata1, 32'h0);
        chk("async reset E wr_err", {31'b0, busE.wr_err}, 32'h0);
        model_reset();
        drive(1'b1, 5'd5, 32'h77, 5'd5, 5'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        #1 chk("write lost in reset", bus32.rdata1, 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // x0 is immutable.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1 chk("x0 read", bus32.rdata1, 32'h0);
        chk("x0 wr_err", {31'b0, bus32.wr_err}, 32'h0);
        chk("x0 read narrow", {24'b0, bus8.rdata1}, 32'h0);

        // Full sweep.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h1000_0000 + i, 5'(i), 5'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            chk($sformatf("sweep p1 x%0d", i), bus32.rdata1, (i == 0) ? 32'h0 : 32'h1000_0000 + i);
            chk($sformatf("sweep p2 x%0d", 31 - i), bus32.rdata2, (i == 31) ? 32'h0 : 32'h1000_0000 + 31 - i);
        end

        // Read during write of x7.
        step(1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
`ifdef RV523_REGFILE_BYPASS_EN
        #2 chk("rdw before edge", bus32.rdata1, 32'h22);
`else
        #2 chk("rdw before edge", bus32.rdata1, 32'h11);
`endif
        @(posedge clk);
        model_edge();
        #1 chk("rdw after edge", bus32.rdata1, 32'h22);
        chk("rdw port2 same", bus32.rdata2, 32'h22);

        // Narrow build.
        step(1'b1, 5'd31, 32'hA5, 5'd31, 5'd0);
        #1 chk("narrow x31", {24'b0, bus8.rdata1}, 32'hA5);
        step(1'b1, 5'd0, 32'hFF, 5'd0, 5'd31);
        #1 chk("narrow x0", {24'b0, bus8.rdata1}, 32'h0);

        // Random traffic; reads often alias the write index.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] wa;
            logic [4:0] r1;
            logic [4:0] r2;
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
        end

        @(negedge clk);
        #4;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_regfile.md
Name: rv_regfile

Overview:
- Parametrised integer register file for the RV523 CPU datapath.
- Built for mapping onto RV523 flip-flop cells plus the NAND2/NOR2/AOI/OAI read-mux cells.
- Two combinational read ports and one synchronous write port; register 0 is hardwired to zero.
- Depth is configurable for RV32I (32 registers) or RV32E (16 registers); width is configurable for reduced-width bring-up builds.

Parameters:
- XLEN, 32, data width in bits (legal 4..32).
- NREGS, 32, number of architectural registers including x0 (legal 16 or 32).
- AW, 5, address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- waddr  input  AW  write register index.
- wdata  input  XLEN  write data.
- raddr1  input  AW  read port 1 index.
- rdata1  output  XLEN  read port 1 data.
- raddr2  input  AW  read port 2 index.
- rdata2  output  XLEN  read port 2 data.
- wr_err  output  1  registered flag: last write targeted an out-of-range index.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers 1..NREGS-1 clear to 0; wr_err clears to 0.
  - Reset dominates clk; writes are suppressed while rst_n is low.
  - Reset release is synchronised externally; no internal synchroniser.
  - Reset asserted mid-write: that write is lost and the register reads 0.
- Write, on the rising clk edge with we=1:
  - 1 <= waddr < NREGS: register[waddr] <= wdata.
  - waddr = 0: no state change; wr_err <= 0.
  - waddr >= NREGS (RV32E build only): no state change; wr_err <= 1.
  - Any in-range write: wr_err <= 0.
  - we=0: wr_err holds its value; no state change.
- Read, both ports fully combinational (zero latency):
  - rdata = register[raddr] for 1 <= raddr < NREGS.
  - raddr = 0: rdata = 0.
  - raddr >= NREGS: rdata = 0.
- Read-during-write, same index in the same cycle: the read returns the OLD value until the edge and the NEW value after it (no bypass unless the Optional Feature is enabled).
- Both read ports may address the same register; each returns an identical value.
- Read mux structure: a binary tree of 2:1 muxes, each mux a single AOI22 plus an inverter per level, so delay scales with AW.
- Width handling: no sign/zero extension is performed; wdata is stored bit-exact.
- Assertions for sim only:
  - Parameters are within their legal ranges.
  - 2**AW >= NREGS.
  - No X on we/waddr while rst_n is high.

Optional Feature:
- Macro: RV523_REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards wdata combinationally when we=1, raddr==waddr, and waddr is a writable in-range index (not 0).
  - The CPU can then read in the same cycle as writeback, removing one hazard stall.
  - The forward path adds one XLEN-wide AOI22 mux stage and an AW-bit comparator per port.
- Undefined: no forwarding; read-during-write behaves exactly as described in Behaviour. The forwarding logic is absent from the netlist.

Test Plan:
- Reset: preload x5=0xDEADBEEF, pulse rst_n low between clock edges -> rdata1 (raddr1=5) drops to 0 immediately, without waiting for a clock edge; wr_err=0.
- x0 immutability: we=1, waddr=0, wdata=0xFFFFFFFF; then raddr1=0 -> rdata1=0x00000000; wr_err=0.
- Full sweep: write regs 1..31 with 0x1000_0000+i, then read all via both ports -> each returns 0x1000_0000+i; raddr1 and raddr2 addressing different registers in the same cycle both return correct values.
- RV32E out of range (NREGS=16): we=1, waddr=20, wdata=0x55 -> wr_err=1 after the edge; raddr1=20 -> 0; next valid write to x3 -> wr_err=0.
- Read-during-write, x7=0x11 then write 0x22 to x7 with raddr1=7:
  - Macro undefined: rdata1=0x11 before the edge, 0x22 after it.
  - Macro defined: rdata1=0x22 before the edge.
- Narrow build (XLEN=8): write 0xA5 to x31 -> reads 0xA5; writes to x0 still read 0.
